// File: rtl/adel_hs_core_if.sv
// Instruction, OUT-channel and debug signals of adel_hs_core bundled as one port.
// The core uses the slave view; an instruction streamer or consumer uses the master view.
interface adel_hs_core_if #(
   parameter int DW  = 8,
   parameter int PCW = 8
);
   logic [15:0]    inst;
   logic           inst_valid;
   logic           inst_ready;
   logic [PCW-1:0] pc;
   logic           halted;
   logic           resume;
   logic [DW-1:0]  out_data;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     dbg_sel;
   logic [DW-1:0]  dbg_data;

   modport master (
      output inst, inst_valid, resume, out_ready, dbg_sel,
      input  inst_ready, pc, halted, out_data, out_valid, dbg_data
   );

   modport slave (
      input  inst, inst_valid, resume, out_ready, dbg_sel,
      output inst_ready, pc, halted, out_data, out_valid, dbg_data
   );
endinterface

// File: rtl/adel_hs_core.sv
// Single-issue accumulator-style core with a 4-entry register file, handshaked instruction
// input, HALT/RESUME, jumps and a backpressured OUT channel.
module adel_hs_core #(
   parameter int DW  = 8,
   parameter int PCW = 8
) (
   input logic           clk,
   input logic           nrst,
   adel_hs_core_if.slave bus
);
   logic [DW-1:0]  rf_reg [4];
   logic [PCW-1:0] pc_reg, pc_next;
   logic           halted_reg, halted_next;
   logic           out_valid_reg, out_valid_next;
   logic [DW-1:0]  out_data_reg, out_data_next;

   logic           w, rs;
   logic [1:0]     opc, dst, src1, src2;
   logic [7:0]     imm;
   logic [DW-1:0]  imm_sx_dw, a, b, alu;
   logic [PCW-1:0] imm_sx_pc, imm_zx_pc, pc_inc;
   logic           inst_ready, fire, taken, rf_we;
   logic [3:0]     rf_wen;

   assign w    = bus.inst[15];
   assign opc  = bus.inst[14:13];
   assign rs   = bus.inst[12];
   assign dst  = bus.inst[11:10];
   assign src1 = bus.inst[9:8];
   assign imm  = bus.inst[7:0];
   assign src2 = bus.inst[1:0];

   assign imm_sx_dw = DW'($signed(imm));
   assign imm_sx_pc = PCW'($signed(imm));
   assign imm_zx_pc = PCW'(imm);
   assign pc_inc    = pc_reg + PCW'(1);

   assign a = rf_reg[src1];
   assign b = rs ? rf_reg[src2] : imm_sx_dw;

   // A pending OUT word that the consumer is refusing blocks further issue.
   assign inst_ready = ~halted_reg & ~(out_valid_reg & ~bus.out_ready);
   assign fire       = bus.inst_valid & inst_ready;

   always_comb begin
      alu = a;
      unique case (opc)
         2'd0: alu = a + b;
         2'd1: alu = a - b;
         2'd2: alu = a & b;
         2'd3: alu = a | b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      unique case (opc)
         2'd0: taken = (a == '0);
         2'd1: taken = a[DW-1];
         2'd2: taken = ~a[DW-1] & (a != '0);
         2'd3: taken = (a != '0);
      endcase
   end

   always_comb begin
      pc_next        = pc_reg;
      halted_next    = halted_reg;
      out_valid_next = out_valid_reg & ~bus.out_ready;
      out_data_next  = out_data_reg;
      rf_we          = 1'b0;
      if (halted_reg & bus.resume)
         halted_next = 1'b0;
      if (fire) begin
         pc_next = pc_inc;
         if (w) begin
            rf_we = 1'b1;
         end else if (!rs) begin
            if (taken)
               pc_next = pc_reg + imm_sx_pc;
         end else begin
            unique case (opc)
               2'd0: halted_next = 1'b1;
               2'd1: begin
                  // Loading a new word overrides the clear from a same-cycle handshake.
                  out_valid_next = 1'b1;
                  out_data_next  = a;
               end
               2'd2: pc_next = imm_zx_pc;
               2'd3: pc_next = pc_inc;
            endcase
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wen
         assign rf_wen[gi] = rf_we & (dst == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pc_reg        <= '0;
         halted_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         for (int i = 0; i < 4; i++)
            rf_reg[i] <= '0;
      end else begin
         pc_reg        <= pc_next;
         halted_reg    <= halted_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         for (int i = 0; i < 4; i++)
            if (rf_wen[i])
               rf_reg[i] <= alu;
      end
   end

   assign bus.inst_ready = inst_ready;
   assign bus.pc         = pc_reg;
   assign bus.halted     = halted_reg;
   assign bus.out_valid  = out_valid_reg;
   assign bus.out_data   = out_data_reg;
   assign bus.dbg_data   = rf_reg[bus.dbg_sel];
endmodule

// File: doc/adel_hs_core.md
Name: adel_hs_core

Overview:
Parametrised successor to the team's 16-bit-instruction accumulator-style core. It has a 4-entry register file of DW-bit signed registers and a PCW-bit program counter. It adds:
- valid/ready instruction handshake with stall;
- HALT/RESUME;
- unconditional jump;
- backpressured OUT channel;
- debug register read port.

It sits between a ROM/instruction-streamer and a downstream consumer of OUT data.

Parameters:
DW, 8, register/data width (>=8)
PCW, 8, program counter width (>=8)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
inst  in  16  instruction word
inst_valid  in  1  inst is valid this cycle
inst_ready  out  1  core accepts inst this cycle
pc  out  PCW  address of next instruction to fetch
halted  out  1  core halted
resume  in  1  leave halt state
out_data  out  DW  OUT channel data
out_valid  out  1  OUT data pending
out_ready  in  1  consumer accepts OUT data
dbg_sel  in  2  debug register select
dbg_data  out  DW  rf[dbg_sel], combinational

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk.
- Reset values: pc=0, rf[0..3]=0, halted=0, out_valid=0, out_data=0.
- Decode fields:
  - w=inst[15], opc=inst[14:13], rs=inst[12], dst=inst[11:10], src1=inst[9:8], imm=inst[7:0], src2=inst[1:0].
  - sx(imm) = imm sign-extended to DW or PCW bits.
- inst_ready = !halted & !(out_valid & !out_ready), combinational.
- fire = inst_valid & inst_ready.
- No fire: pc, rf, halted and out_data hold. out_valid clears only on out_valid & out_ready.
- Fire, w=1 (ALU):
  - rf[dst] <= rf[src1] op B, with B = rs ? rf[src2] : sx(imm).
  - opc 0 ADD, 1 SUB, 2 AND, 3 OR.
  - Result is mod 2^DW; no flags.
  - pc <= pc+1.
- Fire, w=0, rs=0 (conditional branch on signed rf[src1]):
  - opc 0: ==0; opc 1: <0; opc 2: >0; opc 3: !=0.
  - Taken: pc <= pc + sx(imm) mod 2^PCW. Not taken: pc <= pc+1.
- Fire, w=0, rs=1:
  - opc 0 HALT: halted <= 1, pc <= pc+1.
  - opc 1 OUT: out_data <= rf[src1], out_valid <= 1, pc <= pc+1.
  - opc 2 JMP: pc <= zero-extended imm (PCW>8) or imm (PCW=8).
  - opc 3 NOP: pc <= pc+1.
- Register reads use pre-update values; dst==src1 is legal (read old, write new).
- out_valid and out_data are stable until handshake.
- OUT firing in the same cycle as an OUT handshake: new data loads and out_valid stays 1 (set wins over clear).
- resume while halted: halted <= 0 next edge; inst_ready rises that cycle (if OUT not stalled). resume while not halted is ignored.
- An OUT that is still pending is not affected by HALT; the consumer may drain it while halted.
- pc wrap: pc+1 or a branch target past 2^PCW-1 wraps modulo 2^PCW.
- Latency: all effects visible one clk edge after fire; single-issue, no pipeline hazards.
- Reset asserted mid-stall or mid-halt immediately returns every register to its reset value.

Test Plan:
- DW=PCW=8. Reset, then fire 0x8405, 0xA907, 0x22FD -> r1=0x05, r2=0xFE, pc: 1, 2, then 0xFF (branch <0 taken, offset -3).
- OUT 0x3200 with out_ready=0 for 3 cycles ->
  - out_valid=1, out_data=0xFE;
  - inst_ready=0 and pc held for 3 cycles;
  - out_ready=1 -> handshake, out_valid=0, inst_ready=1.
- OUT with out_ready=1, next instruction also OUT (0x3100) -> out_valid stays 1, out_data=rf[1]=0x05 with no gap.
- HALT 0x1000 -> halted=1, inst_ready=0, pc+1. inst_valid held high -> no state change. resume=1 one cycle -> halted=0, next inst executes.
- JMP 0x50FF -> pc=0xFF. NOP 0x7000 -> pc=0x00 (wrap). inst_valid=0 for 4 cycles -> pc and rf unchanged. Branch ==0 on r3=0 with imm 0x02 -> pc+2.
- DW=16, PCW=10:
  - ADD r0 = r0 + 0xFF (0x80FF) -> r0=0xFFFF.
  - JMP 0x50FF -> pc=0x0FF.
  - dbg_sel=0 -> dbg_data=0xFFFF.
  - nrst asserted mid OUT stall -> out_valid=0, pc=0 immediately.
